// File: rtl/vx_mem_responder.sv
// Word-addressed memory endpoint for the core's request/response protocol.
// Reads return in acceptance order after a fixed latency; a credit counter keeps the response queue from overflowing.
module vx_mem_responder #(
  parameter int DATA_WIDTH     = 64,
  parameter int DATA_SIZE      = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int TAG_WIDTH      = 8,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [DATA_SIZE-1:0]  req_byteen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_ready
);

  localparam int CNT_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PTR_W = $clog2(RSP_QUEUE_SIZE);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready_q;
  logic [CNT_W-1:0]      occ_q;
  logic [CNT_W-1:0]      occ_d;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  rsp_fire;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [TAG_WIDTH-1:0]  push_tag;

  logic [DATA_WIDTH-1:0] q_data [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  q_tag  [RSP_QUEUE_SIZE];
  logic [PTR_W:0]        wr_ptr_q;
  logic [PTR_W:0]        rd_ptr_q;
  logic                  q_empty;
  logic                  q_full;

  assign req_ready = ready_q;
  assign rd_acc    = req_valid && ready_q && !req_rw;
  assign wr_acc    = req_valid && ready_q && req_rw;
  assign rd_word   = mem[req_addr];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        if (req_byteen[i]) mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
      end
    end
  end

  // Credits cover reads in the pipeline plus queued responses.
  always_comb begin
    occ_d = occ_q;
    case ({rd_acc, rsp_fire})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= (occ_d < CNT_W'(RSP_QUEUE_SIZE));
    end
  end

  // The queue write is the final latency stage, so only LATENCY-1 pipe registers exist.
  if (LATENCY == 1) begin : g_direct
    assign push_valid = rd_acc;
    assign push_data  = rd_word;
    assign push_tag   = req_tag;
  end else begin : g_pipe
    logic [LATENCY-2:0]    pv_q;
    logic [DATA_WIDTH-1:0] pd_q [LATENCY-1];
    logic [TAG_WIDTH-1:0]  pt_q [LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pv_q <= '0;
      end else begin
        pv_q[0] <= rd_acc;
        for (int k = 1; k < LATENCY - 1; k++) pv_q[k] <= pv_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      pd_q[0] <= rd_word;
      pt_q[0] <= req_tag;
      for (int k = 1; k < LATENCY - 1; k++) begin
        pd_q[k] <= pd_q[k-1];
        pt_q[k] <= pt_q[k-1];
      end
    end

    assign push_valid = pv_q[LATENCY-2];
    assign push_data  = pd_q[LATENCY-2];
    assign push_tag   = pt_q[LATENCY-2];
  end

  assign q_empty   = (wr_ptr_q == rd_ptr_q);
  assign q_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rsp_valid = !q_empty;
  assign rsp_data  = q_data[rd_ptr_q[PTR_W-1:0]];
  assign rsp_tag   = q_tag[rd_ptr_q[PTR_W-1:0]];
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_valid) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (rsp_fire)   rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid) begin
      q_data[wr_ptr_q[PTR_W-1:0]] <= push_data;
      q_tag[wr_ptr_q[PTR_W-1:0]]  <= push_tag;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push_valid && q_full));

endmodule
